multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//  Multicycle MIPS control unit: Moore FSM plus ALU decoder. Drives the datapath muxes and enables,
//  issues the 3-bit ALU_Control code to the ALU, and consumes the ALU zero_flag to resolve branches.
//  Sits between the instruction register (Opcode/Funct) and the shared datapath.
// PARAMETERS
//  OP_WIDTH     6  opcode field width (instr[31:26])
//  FUNCT_WIDTH  6  funct field width (instr[5:0])
//  ALUC_WIDTH   3  ALU_Control width
// PORTS
//  CLK          in   1           single clock; all state updates on rising edge
//  RST          in   1           reset, synchronous, active-low
//  Opcode       in   OP_WIDTH    opcode from the instruction register
//  Funct        in   FUNCT_WIDTH funct field from the instruction register
//  zero_flag    in   1           ALU result == 0; combinational in the current cycle
//  PC_EN        out  1           PCWrite | (Branch & branch_taken)
//  IorD         out  1           0: memory address = PC; 1: memory address = ALUOut
//  MemWrite     out  1           data memory write strobe
//  IRWrite      out  1           instruction register load
//  RegDst       out  1           0: rt; 1: rd
//  MemtoReg     out  1           0: ALUOut; 1: memory data register
//  RegWrite     out  1           register file write
//  ALUSrcA      out  1           0: PC; 1: register A
//  ALUSrcB      out  2           00: B; 01: constant 4; 10: SignImm; 11: SignImm<<2
//  PCSrc        out  2           00: ALU result; 01: ALUOut; 10: jump target
//  ALU_Control  out  ALUC_WIDTH  000 AND, 001 OR, 010 ADD, 100 SUB, 101 MUL, 110 SLT
//  illegal_op   out  1           sticky flag: an unsupported opcode/funct was decoded
// BEHAVIOUR
//  - Reset: while RST=0 at a CLK edge, state <= FETCH and illegal_op <= 0.
//  - Moore outputs are decoded from state only; after reset they equal the FETCH decode.
//  - Any output not listed for a state is 0. ALUOp: 00 ADD; 01 SUB; 10 from Funct.
//  - FETCH: IRWrite=1, PCWrite=1, ALUSrcB=01, ALUOp=00 -> DECODE.
//  - DECODE: ALUSrcB=11, ALUOp=00. Next state by Opcode:
//      lw 100011 / sw 101011 -> MEMADR; R-type 000000 -> EXECUTE; beq 000100 -> BRANCH;
//      addi 001000 -> ADDIEX; j 000010 -> JUMP; any other -> FETCH and set illegal_op.
//  - MEMADR: ALUSrcA=1, ALUSrcB=10. lw -> MEMRD; sw -> MEMWR.
//  - MEMRD: IorD=1 -> MEMWB.   MEMWB: MemtoReg=1, RegWrite=1 -> FETCH.
//  - MEMWR: IorD=1, MemWrite=1 -> FETCH.
//  - EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> ALUWB.   ALUWB: RegDst=1, RegWrite=1 -> FETCH.
//  - BRANCH: ALUSrcA=1, ALUOp=01, PCSrc=01, Branch=1 -> FETCH. branch_taken = zero_flag.
//  - ADDIEX: ALUSrcA=1, ALUSrcB=10 -> ADDIWB.   ADDIWB: RegWrite=1 -> FETCH.
//  - JUMP: PCSrc=10, PCWrite=1 -> FETCH.
//  - Cycles per instruction (FETCH to FETCH): lw 5; sw/R/addi 4; beq/j 3.
//  - ALU decoder (ALUOp=10), Funct to ALU_Control:
//      100000 -> 010; 100010 -> 100; 100100 -> 000; 100101 -> 001; 101010 -> 110; 011000 -> 101.
//      Any other Funct: ALU_Control=010, and illegal_op is set at the EXECUTE edge.
//      The write-back still happens; no trap is raised.
//  - PC_EN is combinational, so zero_flag must be valid in the same BRANCH cycle.
//  - Reset asserted in any state aborts the instruction; next cycle is FETCH with no writes.
//  - Unused state encodings -> FETCH; illegal_op is not set for them.
// CONFIGURATION
//  - MIPS_BNE_EN defined: opcode bne 000101 also goes DECODE -> BRANCH with identical outputs,
//    and branch_taken = ~zero_flag when the latched Opcode is bne.
//  - MIPS_BNE_EN undefined: 000101 is illegal (-> FETCH, illegal_op=1).
// STRUCTURE
//  - Package mips_ctrl_pkg: state enum (4-bit), opcode constants, funct constants,
//    ALUOp codes, ALU_Control codes.
//  - Sub-module alu_decoder (combinational): ALUOp + Funct -> ALU_Control + funct_illegal.
//  - Top level: state register, next-state logic, Moore output decode, illegal_op register, PC_EN.
// TESTING
//  - Reset, then Opcode=100011 held -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB;
//    RegWrite=1 and MemtoReg=1 only in cycle 5; back in FETCH at cycle 6.
//  - Opcode=000000, Funct=101010 -> ALU_Control=110 in EXECUTE; RegDst=1 and RegWrite=1 in ALUWB;
//    4 cycles total.
//  - Opcode=000100 with zero_flag=1 in BRANCH -> PC_EN=1, PCSrc=01.
//    Same with zero_flag=0 -> PC_EN=0.
//  - Opcode=111111 -> DECODE goes to FETCH and illegal_op=1, held across later good instructions
//    until RST=0.
//  - RST=0 asserted during MEMWR -> no MemWrite in the following cycle; state=FETCH, IRWrite=1.
//  - With MIPS_BNE_EN, Opcode=000101, zero_flag=0 -> PC_EN=1.
//    Without it -> illegal_op=1 and no BRANCH state.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared types and constants for the multicycle MIPS control unit:
// FSM state encoding, opcode/funct field values, ALUOp and ALU_Control codes.
package mips_ctrl_pkg;

    localparam int OP_W    = 6;
    localparam int FUNCT_W = 6;
    localparam int ALUC_W  = 3;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_e;

    // Opcode field values (instr[31:26])
    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

    // Funct field values (instr[5:0]) for R-type instructions
    localparam logic [FUNCT_W-1:0] FN_ADD = 6'b100000;
    localparam logic [FUNCT_W-1:0] FN_SUB = 6'b100010;
    localparam logic [FUNCT_W-1:0] FN_AND = 6'b100100;
    localparam logic [FUNCT_W-1:0] FN_OR  = 6'b100101;
    localparam logic [FUNCT_W-1:0] FN_SLT = 6'b101010;
    localparam logic [FUNCT_W-1:0] FN_MUL = 6'b011000;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_e;

    // ALU_Control codes understood by the datapath ALU
    localparam logic [ALUC_W-1:0] ALUC_AND = 3'b000;
    localparam logic [ALUC_W-1:0] ALUC_OR  = 3'b001;
    localparam logic [ALUC_W-1:0] ALUC_ADD = 3'b010;
    localparam logic [ALUC_W-1:0] ALUC_SUB = 3'b100;
    localparam logic [ALUC_W-1:0] ALUC_MUL = 3'b101;
    localparam logic [ALUC_W-1:0] ALUC_SLT = 3'b110;

endpackage

// File: rtl/alu_decoder.sv
// ALU decoder: maps the FSM's ALUOp plus the instruction funct field onto the
// ALU_Control code. Unknown funct values fall back to ADD and raise funct_illegal_o.
module alu_decoder
    import mips_ctrl_pkg::*;
#(
    parameter int FUNCT_WIDTH = FUNCT_W,
    parameter int ALUC_WIDTH  = ALUC_W
) (
    input  aluop_e                 alu_op_i,
    input  logic [FUNCT_WIDTH-1:0] funct_i,
    output logic [ALUC_WIDTH-1:0]  alu_control_o,
    output logic                   funct_illegal_o
);

    // Translate ALUOp/funct into the ALU operation code
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
        alu_control_o   = ALUC_ADD;
        funct_illegal_o = 1'b0;
        case (alu_op_i)
            ALUOP_ADD: alu_control_o = ALUC_ADD;
            ALUOP_SUB: alu_control_o = ALUC_SUB;
            ALUOP_FUNCT: begin
                case (funct_i)
                    FN_ADD:  alu_control_o = ALUC_ADD;
                    FN_SUB:  alu_control_o = ALUC_SUB;
                    FN_AND:  alu_control_o = ALUC_AND;
                    FN_OR:   alu_control_o = ALUC_OR;
                    FN_SLT:  alu_control_o = ALUC_SLT;
                    FN_MUL:  alu_control_o = ALUC_MUL;
                    default: funct_illegal_o = 1'b1;
                endcase
            end
            default: alu_control_o = ALUC_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS control unit: Moore FSM driving datapath muxes/enables, ALU
// decoder instance, sticky illegal-instruction flag and the PC enable.
// Optional build macro MIPS_BNE_EN adds bne (opcode 000101) through the BRANCH state
// with the branch condition inverted; without it bne is reported as illegal.
module multicycle_controller
    import mips_ctrl_pkg::*;
#(
    parameter int OP_WIDTH    = OP_W,
    parameter int FUNCT_WIDTH = FUNCT_W,
    parameter int ALUC_WIDTH  = ALUC_W
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [OP_WIDTH-1:0]    Opcode,
    input  logic [FUNCT_WIDTH-1:0] Funct,
    input  logic                   zero_flag,
    output logic                   PC_EN,
    output logic                   IorD,
    output logic                   MemWrite,
    output logic                   IRWrite,
    output logic                   RegDst,
    output logic                   MemtoReg,
    output logic                   RegWrite,
    output logic                   ALUSrcA,
    output logic [1:0]             ALUSrcB,
    output logic [1:0]             PCSrc,
    output logic [ALUC_WIDTH-1:0]  ALU_Control,
    output logic                   illegal_op
);

    state_e state_q, state_d;
    logic   illegal_q, illegal_d;
    logic   op_illegal;
    logic   funct_illegal;
    logic   pc_write;
    logic   branch;
    logic   branch_taken;
    aluop_e alu_op;

    // State and sticky illegal flag registers
    always_ff @(posedge CLK) begin
        // NOTE: reset is synchronous here, so it only takes effect on a clock edge while RST is low.
        if (!RST) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            // NOTE: registered state uses non-blocking assignments so all flops update together.
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    // Moore output decode and next-state selection from the current state
    always_comb begin
        state_d    = S_FETCH;
        op_illegal = 1'b0;
        pc_write   = 1'b0;
        branch     = 1'b0;
        alu_op     = ALUOP_ADD;
        IorD       = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        PCSrc      = 2'b00;

        case (state_q)
            S_FETCH: begin
                IRWrite  = 1'b1;
                pc_write = 1'b1;
                ALUSrcB  = 2'b01;
                state_d  = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                case (Opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
`ifdef MIPS_BNE_EN
                    OP_BNE:       state_d = S_BRANCH;
`else
                    OP_BNE: begin
                        state_d    = S_FETCH;
                        op_illegal = 1'b1;
                    end
`endif
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        state_d    = S_FETCH;
                        op_illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = (Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                IorD    = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_EXECUTE: begin
                ALUSrcA = 1'b1;
                alu_op  = ALUOP_FUNCT;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA = 1'b1;
                alu_op  = ALUOP_SUB;
                PCSrc   = 2'b01;
                branch  = 1'b1;
                state_d = S_FETCH;
            end
            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: begin
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_JUMP: begin
                PCSrc    = 2'b10;
                pc_write = 1'b1;
                state_d  = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Funct decoding is only active in EXECUTE, so funct_illegal can only fire there
    assign illegal_d  = illegal_q | op_illegal | funct_illegal;
    assign illegal_op = illegal_q;

`ifdef MIPS_BNE_EN
    assign branch_taken = (Opcode == OP_BNE) ? ~zero_flag : zero_flag;
`else
    assign branch_taken = zero_flag;
`endif

    // zero_flag comes straight from the ALU this cycle, so PC_EN is combinational
    assign PC_EN = pc_write | (branch & branch_taken);

    alu_decoder #(
        .FUNCT_WIDTH (FUNCT_WIDTH),
        .ALUC_WIDTH  (ALUC_WIDTH)
    ) u_alu_decoder (
        .alu_op_i        (alu_op),
        .funct_i         (Funct),
        .alu_control_o   (ALU_Control),
        .funct_illegal_o (funct_illegal)
    );

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller. A reference model turns each
// instruction into its list of control steps and the control word each step must show;
// directed cases are followed by randomized instructions, zero flags and resets.
// Honours MIPS_BNE_EN the same way the design does.
module tb_multicycle_controller;

    logic       CLK = 1'b0;
    logic       RST;
    logic [5:0] Opcode;
    logic [5:0] Funct;
    logic       zero_flag;
    logic       PC_EN, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, PCSrc;
    logic [2:0] ALU_Control;
    logic       illegal_op;

    multicycle_controller dut (
        .CLK         (CLK),
        .RST         (RST),
        .Opcode      (Opcode),
        .Funct       (Funct),
        .zero_flag   (zero_flag),
        .PC_EN       (PC_EN),
        .IorD        (IorD),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .RegDst      (RegDst),
        .MemtoReg    (MemtoReg),
        .RegWrite    (RegWrite),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .PCSrc       (PCSrc),
        .ALU_Control (ALU_Control),
        .illegal_op  (illegal_op)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic       pc_en;
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic [2:0] alu_ctrl;
    } word_t;

    typedef enum {
        ST_FETCH, ST_DECODE, ST_MEMADR, ST_MEMRD, ST_MEMWB, ST_MEMWR,
        ST_EXECUTE, ST_ALUWB, ST_BRANCH, ST_ADDIEX, ST_ADDIWB, ST_JUMP
    } step_e;

    word_t obs_w;
    assign obs_w = {PC_EN, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
                    ALUSrcA, ALUSrcB, PCSrc, ALU_Control};

    int    tests = 0;
    int    fails = 0;
    logic  model_illegal = 1'b0;
    step_e plan_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit funct_legal(input logic [5:0] f);
        case (f)
            6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b011000: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] alu_for_funct(input logic [5:0] f);
        case (f)
            6'b100000: return 3'b010;
            6'b100010: return 3'b100;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b110;
            6'b011000: return 3'b101;
            default:   return 3'b010;
        endcase
    endfunction

    function automatic bit is_bne_enabled();
`ifdef MIPS_BNE_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    // Step list an instruction walks through, FETCH to the cycle before the next FETCH
    task automatic build_plan(input logic [5:0] op);
        plan_q = '{ST_FETCH, ST_DECODE};
        case (op)
            6'b100011: begin plan_q.push_back(ST_MEMADR); plan_q.push_back(ST_MEMRD); plan_q.push_back(ST_MEMWB); end
            6'b101011: begin plan_q.push_back(ST_MEMADR); plan_q.push_back(ST_MEMWR); end
            6'b000000: begin plan_q.push_back(ST_EXECUTE); plan_q.push_back(ST_ALUWB); end
            6'b000100: plan_q.push_back(ST_BRANCH);
            6'b000101: if (is_bne_enabled()) plan_q.push_back(ST_BRANCH);
            6'b001000: begin plan_q.push_back(ST_ADDIEX); plan_q.push_back(ST_ADDIWB); end
            6'b000010: plan_q.push_back(ST_JUMP);
            default: ;
        endcase
    endtask

    function automatic word_t step_word(input step_e s, input logic taken, input logic [2:0] r_alu);
        word_t w;
        w = '0;
        w.alu_ctrl = 3'b010;
        case (s)
            ST_FETCH:   begin w.ir_write = 1'b1; w.pc_en = 1'b1; w.alu_src_b = 2'b01; end
            ST_DECODE:  w.alu_src_b = 2'b11;
            ST_MEMADR:  begin w.alu_src_a = 1'b1; w.alu_src_b = 2'b10; end
            ST_MEMRD:   w.iord = 1'b1;
            ST_MEMWB:   begin w.mem_to_reg = 1'b1; w.reg_write = 1'b1; end
            ST_MEMWR:   begin w.iord = 1'b1; w.mem_write = 1'b1; end
            ST_EXECUTE: begin w.alu_src_a = 1'b1; w.alu_ctrl = r_alu; end
            ST_ALUWB:   begin w.reg_dst = 1'b1; w.reg_write = 1'b1; end
            ST_BRANCH:  begin w.alu_src_a = 1'b1; w.alu_ctrl = 3'b100; w.pc_src = 2'b01; w.pc_en = taken; end
            ST_ADDIEX:  begin w.alu_src_a = 1'b1; w.alu_src_b = 2'b10; end
            ST_ADDIWB:  w.reg_write = 1'b1;
            ST_JUMP:    begin w.pc_src = 2'b10; w.pc_en = 1'b1; end
            default: ;
        endcase
        return w;
    endfunction

    // Run one instruction from FETCH. zf_mode 0/1 forces zero_flag, 2 randomizes it per cycle.
    // abort_at >= 0 pulls RST low during that step so the instruction is cut short.
    task automatic run_instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                             input int zf_mode, input int abort_at);
        word_t exp_w;
        logic  taken;
        build_plan(op);
        Opcode = op;
        Funct  = fn;
        for (int i = 0; i < plan_q.size(); i++) begin
            zero_flag = (zf_mode == 2) ? 1'($urandom) : 1'(zf_mode);
            #1;
            taken = (op == 6'b000101 && is_bne_enabled()) ? ~zero_flag : zero_flag;
            exp_w = step_word(plan_q[i], taken, alu_for_funct(fn));
            check($sformatf("%s/%s ctrl", tag, plan_q[i].name()), {17'd0, obs_w}, {17'd0, exp_w});
            check($sformatf("%s/%s illegal_op", tag, plan_q[i].name()), {31'd0, illegal_op}, {31'd0, model_illegal});
            if (i == abort_at) begin
                RST = 1'b0;
                @(posedge CLK);
                #1;
                RST = 1'b1;
                model_illegal = 1'b0;
                return;
            end
            if (plan_q[i] == ST_DECODE && plan_q.size() == 2) model_illegal = 1'b1;
            if (plan_q[i] == ST_EXECUTE && !funct_legal(fn)) model_illegal = 1'b1;
            @(posedge CLK);
            #1;
        end
    endtask

    localparam logic [5:0] OP_TABLE [7] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                                            6'b001000, 6'b000010, 6'b000101};
    localparam logic [5:0] FN_TABLE [6] = '{6'b100000, 6'b100010, 6'b100100,
                                            6'b100101, 6'b101010, 6'b011000};

    initial begin
        logic [5:0] r_op, r_fn;
        int         r_abort;

        // Reset: outputs must show the FETCH decode and illegal_op cleared
        RST       = 1'b0;
        Opcode    = 6'b000000;
        Funct     = 6'b000000;
        zero_flag = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check("reset ctrl", {17'd0, obs_w}, {17'd0, step_word(ST_FETCH, 1'b0, 3'b010)});
        check("reset illegal_op", {31'd0, illegal_op}, 32'd0);
        RST = 1'b1;

        // Directed instructions
        run_instr("lw",        6'b100011, 6'b000000, 2, -1);
        run_instr("r_slt",     6'b000000, 6'b101010, 2, -1);
        run_instr("beq_taken", 6'b000100, 6'b000000, 1, -1);
        run_instr("beq_not",   6'b000100, 6'b000000, 0, -1);
        run_instr("addi",      6'b001000, 6'b000000, 2, -1);
        run_instr("j",         6'b000010, 6'b000000, 2, -1);
        run_instr("sw",        6'b101011, 6'b000000, 2, -1);
        run_instr("bad_op",    6'b111111, 6'b000000, 2, -1);
        run_instr("lw_sticky", 6'b100011, 6'b000000, 2, -1);
        run_instr("r_sticky",  6'b000000, 6'b100000, 2, -1);
        // Reset during MEMWR: the next cycle is FETCH with no write and the flag cleared
        run_instr("sw_abort",  6'b101011, 6'b000000, 2, 3);
        run_instr("after_rst", 6'b000000, 6'b100100, 2, -1);
        run_instr("bne_zf0",   6'b000101, 6'b000000, 0, -1);
        run_instr("bne_zf1",   6'b000101, 6'b000000, 1, -1);
        run_instr("r_badfn",   6'b000000, 6'b111111, 2, 0);
        run_instr("r_badfn2",  6'b000000, 6'b000001, 2, -1);
        run_instr("r_mul",     6'b000000, 6'b011000, 2, -1);

        // Randomized instruction mix with occasional resets mid-instruction
        for (int n = 0; n < 300; n++) begin
            r_op    = ($urandom_range(0, 9) < 7) ? OP_TABLE[$urandom_range(0, 6)] : 6'($urandom);
            r_fn    = $urandom_range(0, 1) ? FN_TABLE[$urandom_range(0, 5)] : 6'($urandom);
            r_abort = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 4)) : -1;
            run_instr($sformatf("rnd%0d", n), r_op, r_fn, 2, r_abort);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
